imem_loader: RTL and testbench

- Boot-time program loader that fills instruction memory before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and packs byte pairs high-byte-first into 16-bit instruction words.
- Drives the instruction memory write port: write enable, data and address.
- Raises cpu_run when the requested word count is written; top level uses cpu_run to select the memory port (loader vs fetch) and to release the CPU.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_loader.sv | 123 ++++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared constants for the instruction memory, its boot loader and the fetch path.
package imem_pkg;

   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 16;
   localparam int DEPTH_DEF  = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HI    = 3'd1,
      ST_LO    = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // A new load may only begin from rest: before the first load or after a finished one.
   function automatic logic accepts_start(input state_e s);
      return (s == ST_IDLE) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream high-byte-first into 16-bit words and writes
// them to instruction memory, then releases the CPU via cpu_run.
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] len,
   input  logic [7:0]        byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              we_IM,
   output logic [DATA_W-1:0] dataIM,
   output logic [ADDR_W-1:0] addIM,
   output logic              busy,
   output logic              done,
   output logic              cpu_run,
   output logic              clamped
);

   // Counter must hold DEPTH itself so a full-memory load can be compared against len.
   localparam int CNT_W = $clog2(DEPTH + 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [7:0]        hi_q, hi_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              clamped_q, clamped_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      hi_d       = hi_q;
      we_d       = 1'b0;
      data_d     = data_q;
      addr_d     = addr_q;
      clamped_d  = clamped_q;
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      cnt_inc    = cnt_q + CNT_W'(1);

      case (state_q)
         ST_IDLE, ST_DONE: begin
            done = (state_q == ST_DONE);
            if (start && accepts_start(state_q)) begin
               cnt_d = '0;
               if (len > ADDR_W'(DEPTH)) begin
                  len_d     = CNT_W'(DEPTH);
                  clamped_d = 1'b1;
               end else begin
                  len_d     = CNT_W'(len);
                  clamped_d = 1'b0;
               end
               state_d = (len == '0) ? ST_DONE : ST_HI;
            end
         end
         ST_HI: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) begin
               hi_d    = byte_in;
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid) begin
               we_d    = 1'b1;
               data_d  = DATA_W'({hi_q, byte_in});
               addr_d  = ADDR_W'(cnt_q);
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            busy    = 1'b1;
            cnt_d   = cnt_inc;
            state_d = (cnt_inc == len_q) ? ST_DONE : ST_HI;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         hi_q      <= '0;
         we_q      <= 1'b0;
         data_q    <= '0;
         addr_q    <= '0;
         clamped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         hi_q      <= hi_d;
         we_q      <= we_d;
         data_q    <= data_d;
         addr_q    <= addr_d;
         clamped_q <= clamped_d;
      end
   end

   assign we_IM   = we_q;
   assign dataIM  = data_q;
   assign addIM   = addr_q;
   assign clamped = clamped_q;
   assign cpu_run = done;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued when a load is
// issued and popped by an independent monitor whenever we_IM is seen.
module tb_imem_loader;
   import imem_pkg::*;

   localparam int AW  = 12;
   localparam int DW  = 16;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] len = '0;
   logic [7:0]    byte_in = '0;
   logic          byte_valid = 1'b0;
   logic          byte_ready, we_IM, busy, done, cpu_run, clamped;
   logic [DW-1:0] dataIM;
   logic [AW-1:0] addIM;

   int checks = 0;
   int fails  = 0;

   logic [7:0]    stim[$];
   logic [AW-1:0] exp_addr[$];
   logic [DW-1:0] exp_data[$];
   bit            exp_nonzero = 1'b0;
   logic          done_prev = 1'b0;
   logic          we_prev = 1'b0;
   logic [AW-1:0] mon_ea;
   logic [DW-1:0] mon_ed;

   imem_loader #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len(len),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .we_IM(we_IM), .dataIM(dataIM), .addIM(addIM),
      .busy(busy), .done(done), .cpu_run(cpu_run), .clamped(clamped)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every we_IM pulse must match the oldest outstanding expected write.
   always @(negedge clk) begin
      if (!rst_n) begin
         done_prev <= 1'b0;
         we_prev   <= 1'b0;
      end else begin
         check("cpu_run_eq_done", cpu_run, done);
         if (we_IM) begin
            if (exp_addr.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_write: addIM=0x%0h dataIM=0x%0h, expected no write", addIM, dataIM);
            end else begin
               mon_ea = exp_addr.pop_front();
               mon_ed = exp_data.pop_front();
               check("write_addr", addIM, mon_ea);
               check("write_data", dataIM, mon_ed);
               $display("write addr=%0d data=0x%04h", addIM, dataIM);
            end
         end
         if (done && !done_prev) check("done_one_cycle_after_last_write", we_prev, exp_nonzero);
         done_prev <= done;
         we_prev   <= we_IM;
      end
   end

   task automatic fill_random(input int nbytes);
      stim.delete();
      for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
   endtask

   // Reference: first min(len,DEPTH) byte pairs become words at consecutive addresses.
   task automatic push_expected(input int len_v, output int n);
      n = (len_v > DEP) ? DEP : len_v;
      for (int i = 0; i < n; i++) begin
         exp_addr.push_back(AW'(i));
         exp_data.push_back({stim[2*i], stim[2*i+1]});
      end
   endtask

   task automatic issue_start(input int len_v, input int n);
      @(negedge clk);
      start       = 1'b1;
      len         = AW'(len_v);
      exp_nonzero = (n != 0);
      @(negedge clk);
      start = 1'b0;
      len   = AW'($urandom);
      check("cpu_run_after_start", cpu_run, (n == 0));
      check("clamped", clamped, (len_v > DEP));
   endtask

   // mode 0: valid always; mode 1: 1-0-1 then 3-cycle gap; mode 2: random.
   task automatic feed(input int mode, input int stop_after, output int consumed);
      int idx = 0;
      int k = 0;
      bit fire = 1'b0;
      bit v;
      while (1) begin
         if (fire) idx++;
         if (done) break;
         if (stop_after >= 0 && idx == stop_after) break;
         if (k > 400) begin
            checks++;
            fails++;
            $display("FAIL load_timeout: consumed %0d bytes, done never rose", idx);
            break;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = ((k % 6) == 0) || ((k % 6) == 2);
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         if (idx >= stim.size()) v = 1'b0;
         byte_valid = v;
         byte_in    = v ? stim[idx] : 8'($urandom);
         fire       = v && byte_ready;
         @(negedge clk);
         k++;
      end
      byte_valid = 1'b0;
      consumed   = idx;
   endtask

   task automatic do_load(input int len_v, input int mode);
      int n, consumed;
      push_expected(len_v, n);
      issue_start(len_v, n);
      feed(mode, -1, consumed);
      byte_valid = 1'b1;
      byte_in    = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         check("byte_ready_in_done", byte_ready, 1'b0);
         @(negedge clk);
      end
      byte_valid = 1'b0;
      check("bytes_consumed", consumed, 2 * n);
      check("writes_outstanding", exp_addr.size(), 0);
      check("done_held", done, 1'b1);
      $display("load len=%0d words=%0d consumed=%0d clamped=%0d", len_v, n, consumed, clamped);
   endtask

   task automatic reset_mid_load(input int len_v, input int stop_after, input int remaining);
      int n, consumed;
      fill_random(2 * len_v);
      push_expected(len_v, n);
      issue_start(len_v, n);
      feed(0, stop_after, consumed);
      #1 rst_n = 1'b0;
      #1;
      check("rst_we_IM", we_IM, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_byte_ready", byte_ready, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_cpu_run", cpu_run, 1'b0);
      check("rst_clamped", clamped, 1'b0);
      check("writes_before_reset", exp_addr.size(), remaining);
      exp_addr.delete();
      exp_data.delete();
      #1 rst_n = 1'b1;
      $display("async reset after %0d bytes of len=%0d load", consumed, len_v);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("reset_byte_ready", byte_ready, 1'b0);
      check("reset_we_IM", we_IM, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_cpu_run", cpu_run, 1'b0);
      check("reset_clamped", clamped, 1'b0);
      check("reset_dataIM", dataIM, 0);
      check("reset_addIM", addIM, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      stim.delete();
      do_load(0, 0);

      stim.delete();
      stim.push_back(8'h12); stim.push_back(8'h34);
      stim.push_back(8'hAB); stim.push_back(8'hCD);
      do_load(2, 0);
      do_load(2, 1);

      fill_random(40);
      do_load(20, 0);

      reset_mid_load(5, 7, 2);
      stim.delete();
      stim.push_back(8'h55); stim.push_back(8'hAA);
      do_load(1, 0);

      stim.delete();
      stim.push_back(8'hFF); stim.push_back(8'h00);
      do_load(1, 0);

      reset_mid_load(2, 2, 1);

      for (int t = 0; t < 8; t++) begin
         int lv, nw;
         lv = $urandom_range(0, 20);
         nw = (lv > DEP) ? DEP : lv;
         fill_random(2 * nw + $urandom_range(0, 6));
         do_load(lv, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
